alu_multibyte_seq: RTL and testbench

Multi-cycle sequencer that drives the 8-bit ALU interface (SEL, A, B, CIN in; RESULT, C, Z out) from the initiator side. It executes NBYTES-wide arithmetic, compare and shift operations by issuing one ALU byte operation per clock and chaining the carry/borrow. It sits between the control unit and the ALU, so the 8-bit datapath can process 16/24/32-bit operands without widening the ALU.

---
 rtl/alu_multibyte_seq.sv | 172 +++++++++++++++++
 tb/tb_alu_multibyte_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multibyte_seq.sv
// Multi-byte sequencer driving an 8-bit ALU one byte per clock.
// Chains carry/borrow to build 16..32-bit add, sub, compare and shifts.
module alu_multibyte_seq #(
    parameter int NBYTES = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [2:0]            OP,
    input  logic [8*NBYTES-1:0]   OPA,
    input  logic [8*NBYTES-1:0]   OPB,
    input  logic                  CIN_IN,
    output logic [3:0]            ALU_SEL,
    output logic [7:0]            ALU_A,
    output logic [7:0]            ALU_B,
    output logic                  ALU_CIN,
    input  logic [7:0]            ALU_RESULT,
    input  logic                  ALU_C,
    input  logic                  ALU_Z,
    output logic [8*NBYTES-1:0]   RES,
    output logic                  C_OUT,
    output logic                  Z_OUT,
    output logic                  BUSY,
    output logic                  DONE
);
    localparam int KW = (NBYTES > 2) ? 2 : 1;
    localparam logic [KW-1:0] LAST = KW'(NBYTES - 1);

    typedef logic [NBYTES-1:0][7:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADDC = 3'd1,
        OP_SUB  = 3'd2,
        OP_SUBC = 3'd3,
        OP_CMP  = 3'd4,
        OP_LSL  = 3'd5,
        OP_LSR  = 3'd6,
        OP_ILL  = 3'd7
    } op_t;

    state_t          state_q;
    state_t          state_d;
    op_t             op_q;
    word_t           a_q;
    word_t           b_q;
    word_t           work_q;
    word_t           work_d;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   cnt_q;
    logic            cr_q;
    logic            za_q;
    logic [8*NBYTES-1:0] res_q;
    logic            c_q;
    logic            z_q;

    logic            accept;
    logic            first;
    logic            last;
    logic            is_shift;

    assign accept   = (state_q == S_IDLE) && START && (OP != 3'd7);
    assign first    = (cnt_q == '0);
    assign last     = (cnt_q == LAST);
    assign is_shift = (op_q == OP_LSL) || (op_q == OP_LSR);

    assign RES   = res_q;
    assign C_OUT = c_q;
    assign Z_OUT = z_q;
    assign BUSY  = (state_q != S_IDLE);
    assign DONE  = (state_q == S_DONE);

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, ALU drive and the work word with the current byte merged in.
    always_comb begin
        state_d         = state_q;
        ALU_SEL         = 4'd14;
        ALU_A           = 8'd0;
        ALU_B           = 8'd0;
        ALU_CIN         = 1'b0;
        work_d          = work_q;
        work_d[k_q]     = ALU_RESULT;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                ALU_A   = a_q[k_q];
                ALU_B   = is_shift ? 8'd0 : b_q[k_q];
                ALU_CIN = cr_q;
                unique case (1'b1)
                    (op_q == OP_ADD):  ALU_SEL = first ? 4'd0 : 4'd1;
                    (op_q == OP_ADDC): ALU_SEL = 4'd1;
                    (op_q == OP_SUB),
                    (op_q == OP_CMP):  ALU_SEL = first ? 4'd2 : 4'd3;
                    (op_q == OP_SUBC): ALU_SEL = 4'd3;
                    (op_q == OP_LSL):  ALU_SEL = 4'd9;
                    (op_q == OP_LSR):  ALU_SEL = 4'd10;
                    default:           ALU_SEL = 4'd14;
                endcase
                // Plain ADD/SUB start with no carry whatever CIN_IN was.
                if (first && (op_q == OP_ADD || op_q == OP_SUB)) begin
                    ALU_CIN = 1'b0;
                end
                if (last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand latch, per-byte accumulation and final result capture.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            work_q <= '0;
            k_q    <= '0;
            cnt_q  <= '0;
            cr_q   <= 1'b0;
            za_q   <= 1'b0;
            res_q  <= '0;
            c_q    <= 1'b0;
            z_q    <= 1'b0;
        end else if (accept) begin
            op_q  <= op_t'(OP);
            a_q   <= OPA;
            b_q   <= OPB;
            k_q   <= (OP == 3'd6) ? LAST : '0;
            cnt_q <= '0;
            cr_q  <= CIN_IN;
            za_q  <= 1'b1;
        end else if (state_q == S_RUN) begin
            work_q <= work_d;
            cr_q   <= ALU_C;
            za_q   <= za_q & ALU_Z;
            cnt_q  <= cnt_q + KW'(1);
            k_q    <= (op_q == OP_LSR) ? k_q - KW'(1) : k_q + KW'(1);
            if (last) begin
                if (op_q != OP_CMP) begin
                    res_q <= work_d;
                end
                c_q <= ALU_C;
                z_q <= za_q & ALU_Z;
            end
        end
    end

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Bench for alu_multibyte_seq with a behavioural 8-bit ALU responder.
// Expected words go to a scoreboard at START and are checked at DONE.
module tb_alu_multibyte_seq;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [2:0]  OP;
    logic [15:0] OPA;
    logic [15:0] OPB;
    logic        CIN_IN;
    logic [3:0]  ALU_SEL;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic        ALU_CIN;
    logic [7:0]  ALU_RESULT;
    logic        ALU_C;
    logic        ALU_Z;
    logic [15:0] RES;
    logic        C_OUT;
    logic        Z_OUT;
    logic        BUSY;
    logic        DONE;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        z;
    } exp_t;

    exp_t        sb[$];
    int          n_tests;
    int          n_fail;
    logic [15:0] last_res;
    logic        last_c;
    logic        last_z;

    alu_multibyte_seq #(.NBYTES(2)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START      (START),
        .OP         (OP),
        .OPA        (OPA),
        .OPB        (OPB),
        .CIN_IN     (CIN_IN),
        .ALU_SEL    (ALU_SEL),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_CIN    (ALU_CIN),
        .ALU_RESULT (ALU_RESULT),
        .ALU_C      (ALU_C),
        .ALU_Z      (ALU_Z),
        .RES        (RES),
        .C_OUT      (C_OUT),
        .Z_OUT      (Z_OUT),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // 8-bit ALU responder: 0 ADD, 1 ADDC, 2 SUB, 3 SUBC, 9 LSL, 10 LSR, 14 MOV.
    always_comb begin
        logic [8:0] t;
        t = 9'd0;
        case (ALU_SEL)
            4'd0:    t = {1'b0, ALU_A} + {1'b0, ALU_B};
            4'd1:    t = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'd0, ALU_CIN};
            4'd2:    t = {1'b0, ALU_A} - {1'b0, ALU_B};
            4'd3:    t = {1'b0, ALU_A} - {1'b0, ALU_B} - {8'd0, ALU_CIN};
            4'd9:    t = {ALU_A[7], ALU_A[6:0], ALU_CIN};
            4'd10:   t = {ALU_A[0], ALU_CIN, ALU_A[7:1]};
            4'd14:   t = {1'b0, ALU_A};
            default: t = 9'd0;
        endcase
        ALU_RESULT = t[7:0];
        ALU_C      = t[8];
        ALU_Z      = (t[7:0] == 8'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] e_res,
                          input logic e_c, input logic e_z,
                          input logic [3:0] s0, input logic [3:0] s1,
                          input logic [7:0] a0, input logic [7:0] a1,
                          input bit poke);
        exp_t       e;
        exp_t       got;
        int         n;
        logic [3:0] sel_seen[2];
        logic [7:0] a_seen[2];
        e.res = e_res;
        e.c   = e_c;
        e.z   = e_z;
        sb.push_back(e);
        OP     = op;
        OPA    = a;
        OPB    = b;
        CIN_IN = cin;
        START  = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        n = 0;
        while (DONE !== 1'b1 && n < 8) begin
            if (n < 2) begin
                sel_seen[n] = ALU_SEL;
                a_seen[n]   = ALU_A;
            end
            check({tag, "/hold"}, 32'({RES, C_OUT, Z_OUT}),
                  32'({last_res, last_c, last_z}));
            if (poke && n == 0) begin
                START = 1'b1;
                OP    = 3'd5;
                OPA   = 16'hA5A5;
            end
            @(posedge CLK); #1;
            START = 1'b0;
            n++;
        end
        check({tag, "/latency"}, 32'(n), 32'd2);
        check({tag, "/done"}, 32'(DONE), 32'd1);
        check({tag, "/sel0"}, 32'(sel_seen[0]), 32'(s0));
        check({tag, "/sel1"}, 32'(sel_seen[1]), 32'(s1));
        check({tag, "/a0"}, 32'(a_seen[0]), 32'(a0));
        check({tag, "/a1"}, 32'(a_seen[1]), 32'(a1));
        check({tag, "/sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check({tag, "/res"}, 32'(RES), 32'(got.res));
            check({tag, "/c"}, 32'(C_OUT), 32'(got.c));
            check({tag, "/z"}, 32'(Z_OUT), 32'(got.z));
            last_res = got.res;
            last_c   = got.c;
            last_z   = got.z;
        end
        if (poke) begin
            START = 1'b1;
            OP    = 3'd0;
            OPA   = 16'h5A5A;
        end
        @(posedge CLK); #1;
        START = 1'b0;
        check({tag, "/done_pulse"}, 32'(DONE), 32'd0);
        check({tag, "/idle"}, 32'(BUSY), 32'd0);
        check({tag, "/res_hold"}, 32'(RES), 32'(e_res));
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        last_res = 16'd0;
        last_c   = 1'b0;
        last_z   = 1'b0;
        RST_N    = 1'b0;
        START    = 1'b0;
        OP       = 3'd0;
        OPA      = 16'd0;
        OPB      = 16'd0;
        CIN_IN   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst/res", 32'(RES), 32'd0);
        check("rst/flags", 32'({C_OUT, Z_OUT, BUSY, DONE}), 32'd0);
        check("rst/alu_sel", 32'(ALU_SEL), 32'd14);
        check("rst/alu_ab", 32'({ALU_A, ALU_B, ALU_CIN}), 32'd0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        run_op("add",   3'd0, 16'h00FF, 16'h0001, 1'b1, 16'h0100, 1'b0, 1'b0,
               4'd0, 4'd1, 8'hFF, 8'h00, 1'b0);
        run_op("sub1",  3'd2, 16'h0100, 16'h0001, 1'b1, 16'h00FF, 1'b0, 1'b0,
               4'd2, 4'd3, 8'h00, 8'h01, 1'b0);
        run_op("sub2",  3'd2, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0,
               4'd2, 4'd3, 8'h00, 8'h00, 1'b0);
        run_op("cmp",   3'd4, 16'h1234, 16'h1234, 1'b0, 16'hFFFF, 1'b0, 1'b1,
               4'd2, 4'd3, 8'h34, 8'h12, 1'b0);
        run_op("addc",  3'd1, 16'hFFFE, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b1,
               4'd1, 4'd1, 8'hFE, 8'hFF, 1'b0);
        run_op("lsl",   3'd5, 16'h8001, 16'hFFFF, 1'b1, 16'h0003, 1'b1, 1'b0,
               4'd9, 4'd9, 8'h01, 8'h80, 1'b0);
        run_op("lsr",   3'd6, 16'h8001, 16'hFFFF, 1'b0, 16'h4000, 1'b1, 1'b0,
               4'd10, 4'd10, 8'h80, 8'h01, 1'b0);
        run_op("subc",  3'd3, 16'h0300, 16'h0100, 1'b1, 16'h01FF, 1'b0, 1'b0,
               4'd3, 4'd3, 8'h00, 8'h03, 1'b0);
        run_op("poke",  3'd0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0,
               4'd0, 4'd1, 8'h11, 8'h11, 1'b1);

        OP    = 3'd7;
        OPA   = 16'hBEEF;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        check("op7/busy", 32'(BUSY), 32'd0);
        @(posedge CLK); #1;
        check("op7/quiet", 32'({BUSY, DONE}), 32'd0);
        check("op7/res", 32'(RES), 32'(last_res));

        OP    = 3'd0;
        OPA   = 16'h00FF;
        OPB   = 16'h0001;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        check("mid_rst/busy", 32'(BUSY), 32'd1);
        @(posedge CLK); #1;
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        check("mid_rst/state", 32'({BUSY, DONE}), 32'd0);
        check("mid_rst/res", 32'(RES), 32'd0);
        check("mid_rst/flags", 32'({C_OUT, Z_OUT}), 32'd0);
        @(posedge CLK); #1;
        check("mid_rst/no_done", 32'({BUSY, DONE}), 32'd0);
        last_res = 16'd0;
        last_c   = 1'b0;
        last_z   = 1'b0;

        run_op("add2",  3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1,
               4'd0, 4'd1, 8'hFF, 8'hFF, 1'b0);

        check("sb/empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
